bcd_digit_cnt: RTL and testbench

Parametrised single-digit time counter for the alarm clock's timekeeping chain: hour tens, hour units, minute tens, minute units and seconds. Generalises the fixed hour-tens register to any width and any [MIN_VAL, MAX_VAL] range. Adds these features:
- Optional decrement.
- Same-cycle carry/borrow outputs for chaining digits.
- Range-checked loads with a sticky error flag.
- An at-limit indication.

One instance sits per digit. Each digit's `carry` feeds the next digit's `inc`.

---
 rtl/bcd_digit_cnt.sv | 83 ++++++++
 tb/tb_bcd_digit_cnt.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_cnt.sv
// rtl/bcd_digit_cnt.sv - parametrised chainable time digit with range-checked load; BCD_DIGIT_DEC_EN enables decrement
module bcd_digit_cnt #(
    parameter int WIDTH     = 4,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 9,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             set,
    input  logic [WIDTH-1:0] new_val,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr_err,
    output logic [WIDTH-1:0] Q,
    output logic             at_max,
    output logic             at_min,
    output logic             carry,
    output logic             borrow,
    output logic             set_err
);

    localparam logic [WIDTH-1:0] MIN_Q   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);

    logic             step_up;
    logic             step_dn;
    logic             load_ok;
    logic [WIDTH-1:0] q_next;
    logic             err_next;

`ifdef BCD_DIGIT_DEC_EN
    assign step_up = inc && !dec && !set;
    assign step_dn = dec && !inc && !set;
`else
    // Without decrement the dec pin is inert, so inc alone decides the step.
    logic unused_dec;
    assign unused_dec = dec;
    assign step_up    = inc && !set;
    assign step_dn    = 1'b0;
`endif

    assign load_ok = (new_val >= MIN_Q) && (new_val <= MAX_Q);
    assign at_max  = (Q == MAX_Q);
    assign at_min  = (Q == MIN_Q);
    // Unregistered so the next digit steps on the same edge this one wraps.
    assign carry   = step_up && at_max;
    assign borrow  = step_dn && at_min;

    always_comb begin
        q_next   = Q;
        err_next = set_err;
        if (clr_err) begin
            err_next = 1'b0;
        end
        if (set) begin
            if (load_ok) begin
                q_next = new_val;
            end else begin
                err_next = 1'b1;
            end
        end else if (step_up) begin
            q_next = at_max ? MIN_Q : Q + 1'b1;
        end
`ifdef BCD_DIGIT_DEC_EN
        else if (step_dn) begin
            q_next = at_min ? MAX_Q : Q - 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            Q       <= RESET_Q;
            set_err <= 1'b0;
        end else begin
            Q       <= q_next;
            set_err <= err_next;
        end
    end

endmodule

// File: tb/tb_bcd_digit_cnt.sv
// tb/tb_bcd_digit_cnt.sv - self-checking bench for bcd_digit_cnt, valid with or without BCD_DIGIT_DEC_EN
module tb_bcd_digit_cnt;

`ifdef BCD_DIGIT_DEC_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: 0..9 units digit; B: 1..12; C: 0..5 tens digit (3 bits) chained from A; R: 0..2
    logic a_set, a_inc, a_dec, a_clr, a_max, a_min, a_carry, a_borrow, a_err;
    logic [3:0] a_nv, a_q;
    logic b_set, b_inc, b_dec, b_clr, b_max, b_min, b_carry, b_borrow, b_err;
    logic [3:0] b_nv, b_q;
    logic c_set, c_inc_tb, c_inc, c_dec, c_clr, c_max, c_min, c_carry, c_borrow, c_err;
    logic [2:0] c_nv, c_q;
    logic r_set, r_max, r_min, r_carry, r_borrow, r_err;
    logic [3:0] r_nv, r_q;

    assign c_inc = a_carry | c_inc_tb;

    bcd_digit_cnt #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .RESET_VAL(0)) u_a (
        .clk(clk), .resetn(resetn), .set(a_set), .new_val(a_nv), .inc(a_inc), .dec(a_dec),
        .clr_err(a_clr), .Q(a_q), .at_max(a_max), .at_min(a_min), .carry(a_carry),
        .borrow(a_borrow), .set_err(a_err));

    bcd_digit_cnt #(.WIDTH(4), .MIN_VAL(1), .MAX_VAL(12), .RESET_VAL(5)) u_b (
        .clk(clk), .resetn(resetn), .set(b_set), .new_val(b_nv), .inc(b_inc), .dec(b_dec),
        .clr_err(b_clr), .Q(b_q), .at_max(b_max), .at_min(b_min), .carry(b_carry),
        .borrow(b_borrow), .set_err(b_err));

    bcd_digit_cnt #(.WIDTH(3), .MIN_VAL(0), .MAX_VAL(5), .RESET_VAL(1)) u_c (
        .clk(clk), .resetn(resetn), .set(c_set), .new_val(c_nv), .inc(c_inc), .dec(c_dec),
        .clr_err(c_clr), .Q(c_q), .at_max(c_max), .at_min(c_min), .carry(c_carry),
        .borrow(c_borrow), .set_err(c_err));

    bcd_digit_cnt #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(2), .RESET_VAL(1)) u_r (
        .clk(clk), .resetn(resetn), .set(r_set), .new_val(r_nv), .inc(1'b1), .dec(1'b0),
        .clr_err(1'b0), .Q(r_q), .at_max(r_max), .at_min(r_min), .carry(r_carry),
        .borrow(r_borrow), .set_err(r_err));

    typedef struct {
        bit set; int nv; bit inc; bit dec; bit clr;
        bit carry; bit borrow; int q; bit err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit set, int nv, bit inc, bit dec, bit clr,
                                bit carry, bit borrow, int q, bit err);
        vec_t v;
        v.set = set; v.nv = nv; v.inc = inc; v.dec = dec; v.clr = clr;
        v.carry = carry; v.borrow = borrow; v.q = q; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: values live in [mn, mx]; stepping is modular arithmetic over that span.
    task automatic model(input int q, input int err, input bit set, input int nv,
                         input bit inc, input bit dec, input bit clr, input int mn, input int mx,
                         output int nq, output int nerr, output bit cy, output bit bw);
        int span;
        bit up, dn;
        span = mx - mn + 1;
        up   = !set && inc && !(DEC_EN && dec);
        dn   = !set && DEC_EN && dec && !inc;
        nq   = q;
        nerr = clr ? 0 : err;
        if (set) begin
            if (nv >= mn && nv <= mx) nq = nv;
            else nerr = 1;
        end else if (up) begin
            nq = mn + (q - mn + 1) % span;
        end else if (dn) begin
            nq = mn + (q - mn + span - 1) % span;
        end
        cy = up && (q == mx);
        bw = dn && (q == mn);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a_set = 0; a_nv = 0; a_inc = 0; a_dec = 0; a_clr = 0;
        b_set = 0; b_nv = 0; b_inc = 0; b_dec = 0; b_clr = 0;
        c_set = 0; c_nv = 0; c_inc_tb = 0; c_dec = 0; c_clr = 0;
        r_set = 0; r_nv = 0;
    endtask

    task automatic b_step(input bit set, input int nv, input bit inc, input bit clr,
                          input string tag, input int exp_q, input int exp_err);
        b_set = set; b_nv = 4'(nv); b_inc = inc; b_clr = clr;
        tick();
        chk({tag, "_q"}, b_q, exp_q);
        chk({tag, "_err"}, b_err, exp_err);
        b_set = 0; b_inc = 0; b_clr = 0;
    endtask

    initial begin
        int mq, merr, nq, nerr, bq, berr;
        bit cy, bw;
        idle_all();

        // Reset overrides a simultaneous load; R has inc tied high too.
        resetn = 0; r_set = 1; r_nv = 4'd2;
        tick();
        chk("rst_r_q", r_q, 1);
        chk("rst_r_err", r_err, 0);
        chk("rst_a_q", a_q, 0);
        chk("rst_a_min", a_min, 1);
        chk("rst_a_max", a_max, 0);
        chk("rst_a_carry", a_carry, 0);
        chk("rst_b_q", b_q, 5);
        chk("rst_c_q", c_q, 1);
        resetn = 1; r_set = 0;

        // Decrement on C from 1: 1 -> 0 -> 5 with decrement, held at 1 without.
        c_dec = 1;
        #1 chk("dec_borrow_q1", c_borrow, 0);
        tick();
        chk("dec_q_a", c_q, DEC_EN ? 0 : 1);
        chk("dec_borrow_q0", c_borrow, DEC_EN ? 1 : 0);
        tick();
        chk("dec_q_b", c_q, DEC_EN ? 5 : 1);
        c_dec = 0;
        #1 chk("dec_borrow_off", c_borrow, 0);

        // Range-checked loads on B (1..12), starting from reset value 5.
        b_step(1, 13, 0, 0, "rng_13", 5, 1);
        b_step(1, 0, 0, 0, "rng_0", 5, 1);
        b_step(0, 0, 0, 1, "rng_clr", 5, 0);
        b_step(1, 12, 0, 0, "rng_12", 12, 0);
        b_inc = 1;
        #1 chk("rng_carry", b_carry, 1);
        b_step(0, 0, 1, 0, "rng_wrap", 1, 0);
        chk("rng_at_min", b_min, 1);

        // Chain: 59 + 1 -> 00 on one edge.
        a_set = 1; a_nv = 4'd9; c_set = 1; c_nv = 3'd5;
        tick();
        a_set = 0; c_set = 0; a_inc = 1;
        #1;
        chk("chain_a_carry", a_carry, 1);
        chk("chain_c_carry", c_carry, 1);
        tick();
        chk("chain_a_q", a_q, 0);
        chk("chain_c_q", c_q, 0);
        a_inc = 0;

        // Table-driven sequence on A (0..9), starting from 0.
        tbl.push_back(mk(1, 8, 0, 0, 0, 0, 0, 8, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 9, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, DEC_EN ? 0 : 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, DEC_EN, DEC_EN ? 9 : 1, 0));
        tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 7, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, DEC_EN ? 7 : 8, 0));
        tbl.push_back(mk(1, 9, 0, 0, 0, 0, 0, 9, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, !DEC_EN, 0, DEC_EN ? 9 : 0, 0));
        tbl.push_back(mk(1, 11, 0, 0, 1, 0, 0, DEC_EN ? 9 : 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, DEC_EN ? 9 : 0, 0));
        tbl.push_back(mk(1, 15, 0, 0, 0, 0, 0, DEC_EN ? 9 : 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 9, 1, 0, 0, 0, 0, 9, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            a_set = tbl[i].set; a_nv = 4'(tbl[i].nv); a_inc = tbl[i].inc;
            a_dec = tbl[i].dec; a_clr = tbl[i].clr;
            #1;
            chk($sformatf("tbl%0d_carry", i), a_carry, tbl[i].carry);
            chk($sformatf("tbl%0d_borrow", i), a_borrow, tbl[i].borrow);
            tick();
            chk($sformatf("tbl%0d_q", i), a_q, tbl[i].q);
            chk($sformatf("tbl%0d_err", i), a_err, tbl[i].err);
            chk($sformatf("tbl%0d_at_max", i), a_max, tbl[i].q == 9);
            chk($sformatf("tbl%0d_at_min", i), a_min, tbl[i].q == 0);
        end
        idle_all();

        // Randomised run on A and B against the reference model.
        mq = tbl[tbl.size()-1].q; merr = tbl[tbl.size()-1].err;
        bq = 1; berr = 0;
        for (int i = 0; i < 300; i++) begin
            a_set = ($urandom_range(0, 5) == 0); a_nv = 4'($urandom_range(0, 15));
            a_inc = $urandom_range(0, 1); a_dec = $urandom_range(0, 1);
            a_clr = ($urandom_range(0, 7) == 0);
            b_set = ($urandom_range(0, 5) == 0); b_nv = 4'($urandom_range(0, 15));
            b_inc = $urandom_range(0, 1); b_dec = $urandom_range(0, 1);
            b_clr = ($urandom_range(0, 7) == 0);
            #1;
            model(mq, merr, a_set, int'(a_nv), a_inc, a_dec, a_clr, 0, 9, nq, nerr, cy, bw);
            chk("rnd_a_carry", a_carry, cy);
            chk("rnd_a_borrow", a_borrow, bw);
            mq = nq; merr = nerr;
            model(bq, berr, b_set, int'(b_nv), b_inc, b_dec, b_clr, 1, 12, nq, nerr, cy, bw);
            chk("rnd_b_carry", b_carry, cy);
            chk("rnd_b_borrow", b_borrow, bw);
            bq = nq; berr = nerr;
            tick();
            chk("rnd_a_q", a_q, mq);
            chk("rnd_a_err", a_err, merr);
            chk("rnd_b_q", b_q, bq);
            chk("rnd_b_err", b_err, berr);
        end
        idle_all();

        // Reset mid-activity wins over set and inc.
        a_set = 1; a_nv = 4'd4; a_inc = 1; resetn = 0;
        tick();
        chk("rst_mid_q", a_q, 0);
        chk("rst_mid_err", a_err, 0);
        resetn = 1;
        idle_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
